flappy_game_ctrl: RTL and testbench

- Parametrised game-control block for the Flappy Bird design.
- Replaces the ad-hoc start1/start2/start3 sequencing and the inline RGB priority logic in the top level.
- Supports N pipes with a configurable spawn spacing, an explicit game-state FSM with pause, a high-score register, a post-crash hold-off, and a registered pixel compositor feeding the video driver.

---
 rtl/flappy_pkg.sv | 31 +++
 rtl/flappy_game_ctrl_pixel_compositor.sv | 74 +++++++
 rtl/flappy_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types, default colours and a bounding-box helper for the Flappy Bird
// game-control slice.
package flappy_pkg;

    // Encoding is visible on the state output: IDLE=0, PLAYING=1, PAUSED=2, OVER=3.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_OVER    = 2'd3
    } game_state_e;

    localparam int unsigned RGB_W        = 24;
    localparam int unsigned BOX_W        = 16;
    localparam logic [23:0] DEF_BG_RGB   = 24'hFFFFFF;
    localparam logic [23:0] DEF_PIPE_RGB = 24'h00FF00;
    localparam logic [23:0] DEF_BIRD_RGB = 24'hFF0000;

    // Inclusive unsigned box test; callers zero-extend coordinates to BOX_W.
    function automatic logic in_box(
        input logic [BOX_W-1:0] px,
        input logic [BOX_W-1:0] py,
        input logic [BOX_W-1:0] x0,
        input logic [BOX_W-1:0] x1,
        input logic [BOX_W-1:0] y0,
        input logic [BOX_W-1:0] y1
    );
        return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
    endfunction

endpackage

// File: rtl/flappy_game_ctrl_pixel_compositor.sv
// Registered pixel compositor: picks blank, pipe, bird or background colour
// for the current pixel, one cycle of latency.
// Ports: clk/reset, blank (force background), packed pipe boxes, bird box,
//        pixel x/y in; registered 24-bit rgb out.
module pixel_compositor
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_PIPES = 3,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 9,
    parameter logic [23:0] BG_RGB    = DEF_BG_RGB,
    parameter logic [23:0] PIPE_RGB  = DEF_PIPE_RGB,
    parameter logic [23:0] BIRD_RGB  = DEF_BIRD_RGB
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     blank,
    input  logic [NUM_PIPES*X_W-1:0] pipe_x0,
    input  logic [NUM_PIPES*X_W-1:0] pipe_x1,
    input  logic [NUM_PIPES*Y_W-1:0] pipe_y0,
    input  logic [NUM_PIPES*Y_W-1:0] pipe_y1,
    input  logic [X_W-1:0]           bird_x0,
    input  logic [X_W-1:0]           bird_x1,
    input  logic [Y_W-1:0]           bird_y0,
    input  logic [Y_W-1:0]           bird_y1,
    input  logic [X_W-1:0]           x,
    input  logic [Y_W-1:0]           y,
    output logic [RGB_W-1:0]         rgb
);

    logic             pipe_hit_c;
    logic             bird_hit_c;
    logic [RGB_W-1:0] colour_c;
    logic [RGB_W-1:0] rgb_q;

    // A pipe covers its column except for the gap between y1 and y0;
    // every pipe shares one colour so lowest-index priority reduces to an OR.
    always_comb begin
        pipe_hit_c = 1'b0;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            if ((x >= pipe_x0[i*X_W +: X_W]) && (x <= pipe_x1[i*X_W +: X_W]) &&
                ((y >= pipe_y0[i*Y_W +: Y_W]) || (y <= pipe_y1[i*Y_W +: Y_W]))) begin
                pipe_hit_c = 1'b1;
            end
        end
    end

    assign bird_hit_c = in_box(BOX_W'(x), BOX_W'(y),
                               BOX_W'(bird_x0), BOX_W'(bird_x1),
                               BOX_W'(bird_y0), BOX_W'(bird_y1));

    // Colour priority: blank, pipe, bird, background.
    always_comb begin
        colour_c = BG_RGB;
        if (blank) begin
            colour_c = BG_RGB;
        end else if (pipe_hit_c) begin
            colour_c = PIPE_RGB;
        end else if (bird_hit_c) begin
            colour_c = BIRD_RGB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= BG_RGB;
        end else begin
            rgb_q <= colour_c;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game-control block: game-state FSM with pause, staggered pipe start,
// post-crash hold-off, high-score register and the pixel compositor.
// Ports: clk/reset; start_game, start_bird, pause_toggle, collision, score_in;
//        packed pipe boxes, bird box and pixel x/y in.
//        pipe_start, bird_run, advance, score_clr, game_over, paused, state,
//        high_score and registered r/g/b out.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_PIPES = 3,
    parameter int unsigned SPAWN_X   = 213,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 9,
    parameter int unsigned SCORE_W   = 7,
    parameter int unsigned OVER_HOLD = 25_000_000,
    parameter logic [23:0] BG_RGB    = DEF_BG_RGB,
    parameter logic [23:0] PIPE_RGB  = DEF_PIPE_RGB,
    parameter logic [23:0] BIRD_RGB  = DEF_BIRD_RGB
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_game,
    input  logic                     start_bird,
    input  logic                     pause_toggle,
    input  logic                     collision,
    input  logic [SCORE_W-1:0]       score_in,
    input  logic [NUM_PIPES*X_W-1:0] pipe_x0,
    input  logic [NUM_PIPES*X_W-1:0] pipe_x1,
    input  logic [NUM_PIPES*Y_W-1:0] pipe_y0,
    input  logic [NUM_PIPES*Y_W-1:0] pipe_y1,
    input  logic [X_W-1:0]           bird_x0,
    input  logic [X_W-1:0]           bird_x1,
    input  logic [Y_W-1:0]           bird_y0,
    input  logic [Y_W-1:0]           bird_y1,
    input  logic [X_W-1:0]           x,
    input  logic [Y_W-1:0]           y,
    output logic [NUM_PIPES-1:0]     pipe_start,
    output logic                     bird_run,
    output logic                     advance,
    output logic                     score_clr,
    output logic                     game_over,
    output logic                     paused,
    output logic [1:0]               state,
    output logic [SCORE_W-1:0]       high_score,
    output logic [7:0]               r,
    output logic [7:0]               g,
    output logic [7:0]               b
);

    localparam int unsigned HOLD_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD - 1);

    game_state_e          state_q;
    logic [NUM_PIPES-1:0] pipe_start_q;
    logic                 bird_run_q;
    logic                 advance_q;
    logic                 score_clr_q;
    logic [SCORE_W-1:0]   high_score_q;
    logic [HOLD_W-1:0]    hold_q;
    logic                 blank_c;
    logic [RGB_W-1:0]     rgb;

    // Game FSM with registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pipe_start_q <= '0;
            bird_run_q   <= 1'b0;
            advance_q    <= 1'b0;
            score_clr_q  <= 1'b0;
            high_score_q <= '0;
            hold_q       <= '0;
        end else begin
            score_clr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_game) begin
                        state_q      <= ST_PLAYING;
                        score_clr_q  <= 1'b1;
                        pipe_start_q <= NUM_PIPES'(1);
                        bird_run_q   <= 1'b1;
                        advance_q    <= 1'b1;
                    end else if (start_bird) begin
                        bird_run_q <= 1'b1;
                        advance_q  <= 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (collision) begin
                        state_q      <= ST_OVER;
                        pipe_start_q <= '0;
                        bird_run_q   <= 1'b0;
                        advance_q    <= 1'b0;
                        hold_q       <= '0;
                        if (score_in > high_score_q) begin
                            high_score_q <= score_in;
                        end
                    end else begin
                        advance_q <= 1'b1;
                        // Each pipe launches once its predecessor reaches the spawn column.
                        for (int unsigned i = 1; i < NUM_PIPES; i++) begin
                            if (pipe_start_q[i-1] &&
                                (pipe_x0[(i-1)*X_W +: X_W] == X_W'(SPAWN_X))) begin
                                pipe_start_q[i] <= 1'b1;
                            end
                        end
                        if (pause_toggle) begin
                            state_q   <= ST_PAUSED;
                            advance_q <= 1'b0;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (pause_toggle) begin
                        state_q   <= ST_PLAYING;
                        advance_q <= 1'b1;
                    end
                end
                ST_OVER: begin
                    // Restart is only accepted once the hold-off counter saturates.
                    if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end else if (start_game) begin
                        state_q      <= ST_PLAYING;
                        score_clr_q  <= 1'b1;
                        pipe_start_q <= NUM_PIPES'(1);
                        bird_run_q   <= 1'b1;
                        advance_q    <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign blank_c = (state_q == ST_IDLE) || (state_q == ST_OVER);

    pixel_compositor #(
        .NUM_PIPES (NUM_PIPES),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .BG_RGB    (BG_RGB),
        .PIPE_RGB  (PIPE_RGB),
        .BIRD_RGB  (BIRD_RGB)
    ) u_pixel_compositor (
        .clk     (clk),
        .reset   (reset),
        .blank   (blank_c),
        .pipe_x0 (pipe_x0),
        .pipe_x1 (pipe_x1),
        .pipe_y0 (pipe_y0),
        .pipe_y1 (pipe_y1),
        .bird_x0 (bird_x0),
        .bird_x1 (bird_x1),
        .bird_y0 (bird_y0),
        .bird_y1 (bird_y1),
        .x       (x),
        .y       (y),
        .rgb     (rgb)
    );

    assign pipe_start = pipe_start_q;
    assign bird_run   = bird_run_q;
    assign advance    = advance_q;
    assign score_clr  = score_clr_q;
    assign game_over  = (state_q == ST_OVER);
    assign paused     = (state_q == ST_PAUSED);
    assign state      = state_q;
    assign high_score = high_score_q;
    assign r          = rgb[23:16];
    assign g          = rgb[15:8];
    assign b          = rgb[7:0];

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl: expected values are queued as
// stimulus is applied and compared after the following clock edge.
module tb_flappy_game_ctrl;

    localparam int unsigned NP = 3;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned SW = 7;

    localparam int S_STATE = 0;
    localparam int S_PIPES = 1;
    localparam int S_BIRD  = 2;
    localparam int S_ADV   = 3;
    localparam int S_CLR   = 4;
    localparam int S_OVER  = 5;
    localparam int S_PAUSE = 6;
    localparam int S_HIGH  = 7;
    localparam int S_RGB   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_game, start_bird, pause_toggle, collision;
    logic [SW-1:0]   score_in;
    logic [NP*XW-1:0] pipe_x0, pipe_x1;
    logic [NP*YW-1:0] pipe_y0, pipe_y1;
    logic [XW-1:0]   bird_x0, bird_x1, x;
    logic [YW-1:0]   bird_y0, bird_y1, y;
    logic [NP-1:0]   pipe_start;
    logic            bird_run, advance, score_clr, game_over, paused;
    logic [1:0]      state;
    logic [SW-1:0]   high_score;
    logic [7:0]      r, g, b;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    flappy_game_ctrl #(
        .NUM_PIPES (NP),
        .X_W       (XW),
        .Y_W       (YW),
        .SCORE_W   (SW),
        .OVER_HOLD (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_game   (start_game),
        .start_bird   (start_bird),
        .pause_toggle (pause_toggle),
        .collision    (collision),
        .score_in     (score_in),
        .pipe_x0      (pipe_x0),
        .pipe_x1      (pipe_x1),
        .pipe_y0      (pipe_y0),
        .pipe_y1      (pipe_y1),
        .bird_x0      (bird_x0),
        .bird_x1      (bird_x1),
        .bird_y0      (bird_y0),
        .bird_y1      (bird_y1),
        .x            (x),
        .y            (y),
        .pipe_start   (pipe_start),
        .bird_run     (bird_run),
        .advance      (advance),
        .score_clr    (score_clr),
        .game_over    (game_over),
        .paused       (paused),
        .state        (state),
        .high_score   (high_score),
        .r            (r),
        .g            (g),
        .b            (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_STATE: return 32'(state);
            S_PIPES: return 32'(pipe_start);
            S_BIRD:  return 32'(bird_run);
            S_ADV:   return 32'(advance);
            S_CLR:   return 32'(score_clr);
            S_OVER:  return 32'(game_over);
            S_PAUSE: return 32'(paused);
            S_HIGH:  return 32'(high_score);
            default: return 32'({r, g, b});
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step_chk();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic set_pipe(input int i, input int a0, input int a1, input int b0, input int b1);
        pipe_x0[i*XW +: XW] = XW'(a0);
        pipe_x1[i*XW +: XW] = XW'(a1);
        pipe_y0[i*YW +: YW] = YW'(b0);
        pipe_y1[i*YW +: YW] = YW'(b1);
    endtask

    int          px[8]  = '{130, 130, 130, 50, 150, 151, 120, 136};
    int          py[8]  = '{100, 255, 250, 50, 300, 100, 265, 255};
    logic [23:0] prgb[8] = '{24'h00FF00, 24'hFF0000, 24'hFF0000, 24'hFFFFFF,
                             24'h00FF00, 24'hFFFFFF, 24'hFF0000, 24'hFFFFFF};

    initial begin
        reset = 1'b1;
        start_game = 1'b0; start_bird = 1'b0; pause_toggle = 1'b0; collision = 1'b0;
        score_in = '0;
        pipe_x0 = '0; pipe_x1 = '0; pipe_y0 = '0; pipe_y1 = '0;
        bird_x0 = XW'(120); bird_x1 = XW'(135);
        bird_y0 = YW'(250); bird_y1 = YW'(265);
        x = XW'(50); y = YW'(50);

        repeat (2) @(posedge clk);
        #1;
        push("rst_state", S_STATE, 0);
        push("rst_pipes", S_PIPES, 0);
        push("rst_bird", S_BIRD, 0);
        push("rst_adv", S_ADV, 0);
        push("rst_clr", S_CLR, 0);
        push("rst_high", S_HIGH, 0);
        push("rst_rgb", S_RGB, 24'hFFFFFF);
        drain();
        reset = 1'b0;

        // Bird-only start in IDLE; spawn column on pipe 0 must not launch pipe 1.
        set_pipe(0, 213, 223, 300, 200);
        start_bird = 1'b1;
        push("bird_state", S_STATE, 0);
        push("bird_run", S_BIRD, 1);
        push("bird_adv", S_ADV, 1);
        push("bird_pipes", S_PIPES, 0);
        step_chk();
        start_bird = 1'b0;

        // Start game with pipe 0 one pixel short of the spawn column.
        set_pipe(0, 212, 222, 300, 200);
        start_game = 1'b1;
        push("go_state", S_STATE, 1);
        push("go_clr", S_CLR, 1);
        push("go_pipes", S_PIPES, 3'b001);
        push("go_bird", S_BIRD, 1);
        push("go_adv", S_ADV, 1);
        step_chk();
        start_game = 1'b0;
        push("clr_pulse", S_CLR, 0);
        push("nospawn1", S_PIPES, 3'b001);
        step_chk();
        push("nospawn2", S_PIPES, 3'b001);
        step_chk();

        pipe_x0[0 +: XW] = XW'(213);
        push("spawn1", S_PIPES, 3'b011);
        step_chk();
        pipe_x0[0 +: XW] = '0;
        pipe_x0[XW +: XW] = XW'(213);
        push("spawn2", S_PIPES, 3'b111);
        step_chk();
        pipe_x0[XW +: XW] = '0;
        push("sticky", S_PIPES, 3'b111);
        step_chk();

        // Pause, then collision and start_game while paused are ignored.
        pause_toggle = 1'b1;
        push("pz_state", S_STATE, 2);
        push("pz_flag", S_PAUSE, 1);
        push("pz_adv", S_ADV, 0);
        push("pz_pipes", S_PIPES, 3'b111);
        push("pz_bird", S_BIRD, 1);
        step_chk();
        pause_toggle = 1'b0;
        collision = 1'b1;
        start_game = 1'b1;
        push("pz_ign_state", S_STATE, 2);
        push("pz_ign_over", S_OVER, 0);
        step_chk();
        collision = 1'b0;
        start_game = 1'b0;

        // Compositor geometry: pipe 0 gap between y=200 and y=300.
        set_pipe(0, 100, 150, 300, 200);
        set_pipe(1, 1000, 1010, 0, 0);
        set_pipe(2, 1000, 1010, 0, 0);
        x = XW'(px[0]); y = YW'(py[0]);
        push("frozen_rgb", S_RGB, prgb[0]);
        step_chk();
        pause_toggle = 1'b1;
        x = XW'(px[1]); y = YW'(py[1]);
        push("unpz_state", S_STATE, 1);
        push("unpz_adv", S_ADV, 1);
        push("unpz_flag", S_PAUSE, 0);
        push("pix1", S_RGB, prgb[1]);
        step_chk();
        pause_toggle = 1'b0;
        for (int k = 2; k < 8; k++) begin
            x = XW'(px[k]); y = YW'(py[k]);
            push($sformatf("pix%0d", k), S_RGB, prgb[k]);
            step_chk();
        end

        // Crash with score 42.
        score_in = SW'(42);
        collision = 1'b1;
        push("ov_state", S_STATE, 3);
        push("ov_flag", S_OVER, 1);
        push("ov_pipes", S_PIPES, 0);
        push("ov_bird", S_BIRD, 0);
        push("ov_adv", S_ADV, 0);
        push("ov_high", S_HIGH, 42);
        step_chk();
        collision = 1'b0;

        // Hold-off: first three OVER cycles reject start_game, fourth accepts.
        x = XW'(130); y = YW'(100);
        start_game = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            if (k == 1) push("ov_blank_rgb", S_RGB, 24'hFFFFFF);
            push($sformatf("hold%0d", k), S_STATE, 3);
            step_chk();
        end
        push("restart_state", S_STATE, 1);
        push("restart_clr", S_CLR, 1);
        push("restart_pipes", S_PIPES, 3'b001);
        push("restart_high", S_HIGH, 42);
        step_chk();
        start_game = 1'b0;

        // Lower score must not replace the high score.
        score_in = SW'(17);
        collision = 1'b1;
        push("ov2_state", S_STATE, 3);
        push("ov2_high", S_HIGH, 42);
        step_chk();
        collision = 1'b0;
        repeat (3) step_chk();
        start_game = 1'b1;
        push("restart2_state", S_STATE, 1);
        step_chk();
        start_game = 1'b0;

        // Collision beats pause_toggle in the same cycle.
        pause_toggle = 1'b1;
        collision = 1'b1;
        push("prio_state", S_STATE, 3);
        push("prio_pause", S_PAUSE, 0);
        step_chk();
        pause_toggle = 1'b0;
        collision = 1'b0;

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        push("areset_state", S_STATE, 0);
        push("areset_high", S_HIGH, 0);
        push("areset_rgb", S_RGB, 24'hFFFFFF);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
